// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter for the frequency display.
// Converts one input bit per clock, holds the last result between conversions
// and saturates counts above 9999 to 16'h9999 with an overflow flag.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 14
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin,
  output logic [15:0]          BCD,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_SHIFT = 4'(BIN_WIDTH - 1);

  state_t               state_q;
  logic [BIN_WIDTH-1:0] binreg_q, binreg_d;
  logic [15:0]          scr_q, scr_d;
  logic [3:0]           cnt_q;
  logic                 ovf_pend_q;
  logic [15:0]          bcd_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ovf_q;

  // One double-dabble step: add 3 to every nibble >= 5, then shift left
  // with the next binary bit entering the units digit.
  function automatic logic [15:0] dabble_shift(input logic [15:0] s,
                                               input logic        in_bit);
    logic [15:0] a;
    a = s;
    for (int n = 0; n < 4; n++) begin
      if (a[n*4 +: 4] >= 4'd5) a[n*4 +: 4] = a[n*4 +: 4] + 4'd3;
    end
    return (a << 1) | {15'b0, in_bit};
  endfunction

  // Next values of the combined {scratch, binreg} shift register.
  always_comb begin
    scr_d    = dabble_shift(scr_q, binreg_q[BIN_WIDTH-1]);
    binreg_d = binreg_q << 1;
  end

  // Control FSM with registered outputs; BCD/overflow change only on the done edge.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= S_IDLE;
      binreg_q   <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= 16'h0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            binreg_q   <= bin;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= (32'(bin) > 32'd9999);
            busy_q     <= 1'b1;
            state_q    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scr_q    <= scr_d;
          binreg_q <= binreg_d;
          cnt_q    <= cnt_q + 4'd1;
          if (cnt_q == LAST_SHIFT) state_q <= S_DONE;
        end
        S_DONE: begin
          // Out-of-range counts have a truncated scratch; force the saturated value.
          bcd_q   <= ovf_pend_q ? 16'h9999 : scr_q;
          ovf_q   <= ovf_pend_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BCD      = bcd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed scenarios plus a randomized
// sweep compared against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

  localparam int W = 14;

  logic          CLK = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  bin;
  logic [15:0]   BCD;
  logic          busy;
  logic          done;
  logic          overflow;

  int vectors = 0;
  int errors  = 0;

  always #5 CLK = ~CLK;

  bin_to_bcd_seq #(.BIN_WIDTH(W)) dut (
    .CLK      (CLK),
    .reset    (reset),
    .start    (start),
    .bin      (bin),
    .BCD      (BCD),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  // Reference: decimal digits by division, saturating above 9999.
  function automatic logic [15:0] ref_bcd(input int v);
    if (v > 9999) return 16'h9999;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one conversion; optionally pulse start (with bin=5678) after
  // inj1/inj2 completed cycles. Returns cycles from accept to done.
  task automatic conv(input int b, input int inj1, input int inj2,
                      output int lat, output int busy_cnt, output bit held);
    logic [15:0] prev_bcd;
    logic        prev_ovf;
    prev_bcd = BCD;
    prev_ovf = overflow;
    start = 1'b1;
    bin   = W'(b);
    tick();
    start = 1'b0;
    bin   = W'($urandom);
    busy_cnt = busy ? 1 : 0;
    lat  = 0;
    held = 1'b1;
    while (lat < 40 && !done) begin
      if (lat == inj1 || lat == inj2) begin
        start = 1'b1;
        bin   = W'(5678);
      end
      tick();
      start = 1'b0;
      lat++;
      if (busy) busy_cnt++;
      if (!done && (BCD !== prev_bcd || overflow !== prev_ovf)) held = 1'b0;
    end
  endtask

  task automatic check_conv(input string tag, input int b);
    int lat, bc;
    bit held, ok;
    conv(b, -1, -1, lat, bc, held);
    chk({tag, "_latency"}, 32'(lat), 32'(W + 1));
    chk({tag, "_bcd"}, 32'(BCD), 32'(ref_bcd(b)));
    chk({tag, "_ovf"}, 32'(overflow), (b > 9999) ? 32'd1 : 32'd0);
    chk({tag, "_busy_cnt"}, 32'(bc), 32'(W + 1));
    chk({tag, "_held"}, 32'(held), 32'd1);
    ok = (BCD[15:12] <= 4'd9) && (BCD[11:8] <= 4'd9) &&
         (BCD[7:4] <= 4'd9) && (BCD[3:0] <= 4'd9);
    chk({tag, "_digits"}, 32'(ok), 32'd1);
  endtask

  initial begin
    int lat, bc, dcnt, bcnt;
    bit held;
    int bounds[10] = '{0, 9, 10, 99, 100, 999, 1000, 9999, 10000, 10050};

    reset = 1'b1;
    start = 1'b1;
    bin   = W'(1234);
    tick();
    tick();
    chk("rst_bcd", 32'(BCD), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Basic conversion
    check_conv("t1_1234", 1234);

    // Back-to-back: each new start issued while done is visible
    check_conv("t2_0", 0);
    check_conv("t2_9999", 9999);

    // Saturation and recovery
    check_conv("t3_10000", 10000);
    check_conv("t3_16383", 16383);
    check_conv("t3_42", 42);

    // Starts while busy (mid-shift and in the DONE-state cycle) are ignored
    conv(1234, 4, 14, lat, bc, held);
    chk("t4_latency", 32'(lat), 32'(W + 1));
    chk("t4_bcd", 32'(BCD), 32'h1234);
    chk("t4_held", 32'(held), 32'd1);
    dcnt = 0;
    bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    chk("t4_extra_done", 32'(dcnt), 32'd0);
    chk("t4_extra_busy", 32'(bcnt), 32'd0);
    chk("t4_bcd_after", 32'(BCD), 32'h1234);

    // Reset abandons a conversion in flight
    start = 1'b1;
    bin   = W'(8765);
    tick();
    start = 1'b0;
    dcnt  = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) dcnt++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_bcd", 32'(BCD), 32'h0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) dcnt++;
    end
    chk("t5_no_done", 32'(dcnt), 32'd0);
    check_conv("t5_8765", 8765);

    // Boundary values, then randomized sweep over 0..10050
    foreach (bounds[i]) check_conv("t6_bound", bounds[i]);
    for (int i = 0; i < 500; i++) begin
      check_conv("t6_rand", int'($urandom_range(10050, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
